iterative_mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 31 +++
 rtl/iterative_mdu_if.sv | 25 ++
 rtl/mdu_step.sv | 39 +++
 rtl/iterative_mdu.sv | 166 ++++++++++++++++
 tb/tb_iterative_mdu.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH      = 32;
  localparam int MDU_ITERATIONS = 32;
  localparam int MDU_CNT_W      = $clog2(MDU_ITERATIONS);

  typedef enum logic [2:0] {
    READ_HI            = 3'd0,
    READ_LO            = 3'd1,
    WRITE_HI           = 3'd2,
    WRITE_LO           = 3'd3,
    START_SIGNED_MUL   = 3'd4,
    START_UNSIGNED_MUL = 3'd5,
    START_SIGNED_DIV   = 3'd6,
    START_UNSIGNED_DIV = 3'd7
  } mdu_operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [MDU_WIDTH-1:0] cond_neg(input logic [MDU_WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/iterative_mdu_if.sv
// Request/response bundle between the EX stage (master) and the MDU (slave).
interface iterative_mdu_if;
  import mdu_pkg::*;

  // Handshake: a state-changing request is taken on a rising edge with start=1
  // and busy=0; start while busy=1 is dropped. Reads are combinational and never
  // need start. busy is a registered output.
  logic [MDU_WIDTH-1:0] operand1;
  logic [MDU_WIDTH-1:0] operand2;
  mdu_operation_t       operation;
  logic                 start;
  logic                 busy;
  logic [MDU_WIDTH-1:0] dataRead;
  mdu_state_t           dbg_state;

  modport master (
    output operand1, operand2, operation, start,
    input  busy, dataRead, dbg_state
  );

  modport slave (
    input  operand1, operand2, operation, start,
    output busy, dataRead, dbg_state
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step.
module mdu_step
  import mdu_pkg::*;
(
  input  logic [2*MDU_WIDTH-1:0] acc_i,
  input  logic [MDU_WIDTH-1:0]   operand_i,
  input  logic [MDU_WIDTH-1:0]   source_i,
  input  logic                   is_div_i,
  input  logic [MDU_CNT_W-1:0]   index_i,
  output logic [2*MDU_WIDTH-1:0] acc_o,
  output logic                   qbit_o
);

  logic                   src_bit;
  logic [2*MDU_WIDTH-1:0] addend;
  logic [MDU_WIDTH:0]     trial;
  logic [MDU_WIDTH:0]     diff;

  always_comb begin
    src_bit = source_i[index_i];
    addend  = {{MDU_WIDTH{1'b0}}, operand_i} << index_i;
    // Partial remainder is always below the divisor, so the shifted trial fits 33 bits.
    trial   = {acc_i[MDU_WIDTH-1:0], src_bit};
    diff    = trial - {1'b0, operand_i};
    acc_o   = acc_i;
    qbit_o  = 1'b0;
    if (is_div_i) begin
      if (trial >= {1'b0, operand_i}) begin
        acc_o  = {{(MDU_WIDTH-1){1'b0}}, diff};
        qbit_o = 1'b1;
      end else begin
        acc_o  = {{(MDU_WIDTH-1){1'b0}}, trial};
      end
    end else if (src_bit) begin
      acc_o = acc_i + addend;
    end
  end

endmodule

// File: rtl/iterative_mdu.sv
// HI/LO owner with a 32-iteration multiply/divide engine; busy stalls the pipeline.
module iterative_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  iterative_mdu_if.slave  mdu
);

  mdu_state_t             state_q, state_d;
  logic [MDU_CNT_W-1:0]   count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   is_div_q, is_div_d;
  logic                   sign1_q, sign1_d;
  logic                   sign2_q, sign2_d;
  logic [WIDTH-1:0]       opa_q, opa_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       quot_q, quot_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic [2*WIDTH-1:0]     step_acc;
  logic                   step_qbit;
  logic [WIDTH-1:0]       step_operand;
  logic [WIDTH-1:0]       step_source;
  logic [MDU_CNT_W-1:0]   step_index;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quot_fix;
  logic [WIDTH-1:0]       rem_fix;
  logic                   accept;
  logic                   is_signed_op;

  // Multiply consumes multiplier bits LSB-first; divide consumes dividend bits MSB-first.
  assign step_operand = is_div_q ? opb_q : opa_q;
  assign step_source  = is_div_q ? opa_q : opb_q;
  assign step_index   = is_div_q ? (MDU_CNT_W'(MDU_ITERATIONS - 1) - count_q) : count_q;

  mdu_step u_step (
    .acc_i     (acc_q),
    .operand_i (step_operand),
    .source_i  (step_source),
    .is_div_i  (is_div_q),
    .index_i   (step_index),
    .acc_o     (step_acc),
    .qbit_o    (step_qbit)
  );

  assign accept       = mdu.start && !busy_q;
  assign is_signed_op = (mdu.operation == START_SIGNED_MUL) ||
                        (mdu.operation == START_SIGNED_DIV);

  always_comb begin
    prod_fix = (sign1_q ^ sign2_q) ? (~acc_q + 1'b1) : acc_q;
    quot_fix = cond_neg(quot_q, sign1_q ^ sign2_q);
    rem_fix  = cond_neg(acc_q[WIDTH-1:0], sign1_q);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    is_div_d = is_div_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    quot_d   = quot_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (mdu.operation)
            WRITE_HI: hi_d = mdu.operand1;
            WRITE_LO: lo_d = mdu.operand1;
            START_SIGNED_MUL, START_UNSIGNED_MUL,
            START_SIGNED_DIV, START_UNSIGNED_DIV: begin
              sign1_d  = is_signed_op && mdu.operand1[WIDTH-1];
              sign2_d  = is_signed_op && mdu.operand2[WIDTH-1];
              opa_d    = cond_neg(mdu.operand1, is_signed_op && mdu.operand1[WIDTH-1]);
              opb_d    = cond_neg(mdu.operand2, is_signed_op && mdu.operand2[WIDTH-1]);
              is_div_d = (mdu.operation == START_SIGNED_DIV) ||
                         (mdu.operation == START_UNSIGNED_DIV);
              acc_d    = '0;
              quot_d   = '0;
              count_d  = '0;
              busy_d   = 1'b1;
              state_d  = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d   = step_acc;
        quot_d  = {quot_q[WIDTH-2:0], step_qbit};
        count_d = count_q + 1'b1;
        if (count_q == MDU_CNT_W'(MDU_ITERATIONS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Divide by zero and the most-negative/-1 case fall out of the plain loop.
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      quot_q   <= quot_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    case (mdu.operation)
      READ_HI: mdu.dataRead = hi_q;
      READ_LO: mdu.dataRead = lo_q;
      default: mdu.dataRead = '0;
    endcase
  end

  assign mdu.busy      = busy_q;
  assign mdu.dbg_state = state_q;

endmodule

// File: tb/tb_iterative_mdu.sv
// Directed bench for iterative_mdu: driver pushes expectations, monitor checks them.
module tb_iterative_mdu;
  import mdu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  iterative_mdu_if bus ();

  iterative_mdu #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .mdu   (bus)
  );

  // Scoreboard: kind 0 = dataRead, 1 = busy, 2 = measured busy-cycle count.
  logic [31:0] exp_q[$];
  logic [1:0]  kind_q[$];
  string       name_q[$];
  int          chk_n = 0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] meas  = '0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  always @(negedge clock) begin
    for (int i = 0; i < chk_n; i++) begin
      logic [31:0] e;
      logic [31:0] act;
      logic [1:0]  k;
      string       nm;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL queue_underflow: no expectation left at %0t", $time);
      end else begin
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        case (k)
          2'd0:    act = bus.dataRead;
          2'd1:    act = {31'b0, bus.busy};
          default: act = meas;
        endcase
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    chk_n = 0;
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    kind_q.push_back(k);
    name_q.push_back(nm);
    chk_n++;
  endtask

  task automatic check_reg(input mdu_operation_t op, input logic [31:0] e, input string nm);
    bus.operation = op;
    bus.start     = 1'b0;
    push(2'd0, e, nm);
    tick();
  endtask

  task automatic write_reg(input mdu_operation_t op, input logic [31:0] v);
    bus.operation = op;
    bus.operand1  = v;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    if (op == WRITE_HI) model_hi = v;
    else                model_lo = v;
  endtask

  task automatic run_op(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    int cycles;
    bus.operation = op;
    bus.operand1  = a;
    bus.operand2  = b;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 60) begin
      cycles++;
      bus.operation = READ_HI;
      bus.start     = 1'b0;
      if (cycles == 5) begin
        bus.operation = READ_LO;
        push(2'd0, model_lo, {nm, "_lo_during_busy"});
      end
      if (cycles == 8) begin
        bus.operation = WRITE_LO;
        bus.operand1  = 32'hDEADBEEF;
        bus.start     = 1'b1;
      end
      if (cycles == 12) begin
        bus.operation = READ_LO;
        push(2'd0, model_lo, {nm, "_lo_after_ignored_write"});
      end
      if (cycles == 20) begin
        bus.operation = START_UNSIGNED_MUL;
        bus.operand1  = 32'd5;
        bus.operand2  = 32'd5;
        bus.start     = 1'b1;
      end
      tick();
    end
    bus.start     = 1'b0;
    bus.operation = READ_HI;
    meas          = cycles;
    push(2'd2, 32'd33, {nm, "_busy_cycles"});
    tick();
    model_hi = exp_hi;
    model_lo = exp_lo;
    check_reg(READ_HI, exp_hi, {nm, "_hi"});
    check_reg(READ_LO, exp_lo, {nm, "_lo"});
  endtask

  initial begin
    reset         = 1'b1;
    bus.operation = READ_HI;
    bus.operand1  = '0;
    bus.operand2  = '0;
    bus.start     = 1'b0;
    tick();
    push(2'd0, 32'h0, "reset_read_hi");
    push(2'd1, 32'h0, "reset_busy");
    tick();
    reset = 1'b0;
    tick();

    write_reg(WRITE_HI, 32'h12345678);
    push(2'd1, 32'h0, "write_busy");
    check_reg(READ_HI, 32'h12345678, "write_hi");
    write_reg(WRITE_LO, 32'hCAFEF00D);
    check_reg(READ_LO, 32'hCAFEF00D, "write_lo");
    check_reg(READ_HI, 32'h12345678, "write_lo_keeps_hi");
    check_reg(WRITE_HI, 32'h0, "dataread_zero_for_write_op");

    bus.operation = WRITE_HI;
    bus.operand1  = 32'h0000FFFF;
    bus.start     = 1'b0;
    tick();
    check_reg(READ_HI, 32'h12345678, "write_without_start");

    reset         = 1'b1;
    bus.operation = READ_LO;
    push(2'd0, 32'h0, "async_reset_lo");
    tick();
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check_reg(READ_HI, 32'h0, "async_reset_hi");

    write_reg(WRITE_LO, 32'h55AA55AA);
    run_op(START_SIGNED_MUL,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "smul_m2x3");
    run_op(START_UNSIGNED_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "umul_max");
    run_op(START_SIGNED_MUL,   32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "smul_7xm6");
    run_op(START_SIGNED_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "sdiv_m7d2");
    run_op(START_UNSIGNED_DIV, 32'd1000,     32'd7,        32'd6,        32'd142,      "udiv_1000d7");
    run_op(START_UNSIGNED_DIV, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "udiv_by_zero");
    run_op(START_SIGNED_DIV,   32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "sdiv_pos_by_zero");
    run_op(START_SIGNED_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'h00000001, "sdiv_neg_by_zero");
    run_op(START_SIGNED_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, "sdiv_overflow");
    run_op(START_SIGNED_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "sdiv_7dm2");

    bus.operation = START_SIGNED_MUL;
    bus.operand1  = 32'd7;
    bus.operand2  = 32'hFFFFFFFE;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.operation = READ_HI;
    repeat (9) tick();
    reset = 1'b1;
    push(2'd1, 32'h0, "midop_reset_busy");
    push(2'd0, 32'h0, "midop_reset_hi");
    tick();
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check_reg(READ_LO, 32'h0, "midop_reset_lo");
    push(2'd1, 32'h0, "midop_reset_stays_idle");
    tick();

    run_op(START_UNSIGNED_MUL, 32'h00010000, 32'h00010000, 32'h00000001, 32'h0, "umul_after_reset");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
